// File: rtl/blur_img_core_if.sv
// Port bundle between the blur engine, its source BRAM read port and the destination memory write port.
// master = blur engine, slave = memories / sequencer driving start_in.
interface blur_img_core_if #(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64
);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  logic [AW-1:0]        ext_read_addr;
  logic                 ext_read_addr_valid;
  logic [BIT_DEPTH-1:0] ext_pixel_in;
  logic [AW-1:0]        ext_write_addr;
  logic                 ext_write_valid;
  logic [BIT_DEPTH-1:0] ext_pixel_out;
  logic                 start_in;
  logic                 blur_done;
  logic                 blur_data_valid_out;
  logic [3:0]           kernel_ind;

  modport master (
    output ext_read_addr, ext_read_addr_valid,
    input  ext_pixel_in,
    output ext_write_addr, ext_write_valid, ext_pixel_out,
    input  start_in,
    output blur_done, blur_data_valid_out, kernel_ind
  );

  modport slave (
    input  ext_read_addr, ext_read_addr_valid,
    output ext_pixel_in,
    input  ext_write_addr, ext_write_valid, ext_pixel_out,
    output start_in,
    input  blur_done, blur_data_valid_out, kernel_ind
  );
endinterface

// File: rtl/blur_img_core.sv
// Sequential 3x3 Gaussian blur (1 2 1 / 2 4 2 / 1 2 1, /16) over a frame in external BRAM, 12 cycles per pixel.
// state | meaning
// IDLE  | waiting for start_in
// READ  | issuing the 9 tap addresses, kernel_ind = tap
// DRAIN | 2 cycles collecting the last taps from the 2-cycle BRAM
// WRITE | write strobe for the current pixel, then advance
// DONE  | one-cycle blur_done pulse
module blur_img_core #(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64
) (
  input logic             clk_in,
  input logic             rst_in,
  blur_img_core_if.master bus
);
  localparam int AW    = $clog2(WIDTH * HEIGHT);
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int ACC_W = BIT_DEPTH + 4;
  localparam logic [AW-1:0] LAST_IDX = AW'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t            state;
  logic [XW-1:0]     x, x_next;
  logic [YW-1:0]     y, y_next;
  logic [AW-1:0]     pix_idx;
  logic              drain_cnt;
  logic [ACC_W-1:0]  acc, acc_next;
  logic              tap_v_d1, tap_v_d2;
  logic [3:0]        tap_k_d1, tap_k_d2;

  // Edge replication: out-of-frame taps reuse the nearest border pixel.
  function automatic logic [AW-1:0] tap_addr(input logic [3:0] k,
                                             input logic [XW-1:0] px,
                                             input logic [YW-1:0] py);
    int cx, cy;
    cx = int'(px) + (int'(k) % 3) - 1;
    cy = int'(py) + (int'(k) / 3) - 1;
    if (cx < 0) cx = 0;
    else if (cx > WIDTH - 1) cx = WIDTH - 1;
    if (cy < 0) cy = 0;
    else if (cy > HEIGHT - 1) cy = HEIGHT - 1;
    return AW'(cy * WIDTH + cx);
  endfunction

  // Read data is only looked at when the delayed issue flag says it belongs to a tap.
  always_comb begin
    acc_next = acc;
    if (tap_v_d2) begin
      case (tap_k_d2)
        4'd4:                acc_next = acc + (ACC_W'(bus.ext_pixel_in) << 2);
        4'd1, 4'd3, 4'd5, 4'd7: acc_next = acc + (ACC_W'(bus.ext_pixel_in) << 1);
        default:             acc_next = acc + ACC_W'(bus.ext_pixel_in);
      endcase
    end
  end

  always_comb begin
    x_next = x + XW'(1);
    y_next = y;
    if (x == XW'(WIDTH - 1)) begin
      x_next = '0;
      y_next = y + YW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                   <= IDLE;
      x                       <= '0;
      y                       <= '0;
      pix_idx                 <= '0;
      drain_cnt               <= 1'b0;
      acc                     <= '0;
      tap_v_d1                <= 1'b0;
      tap_v_d2                <= 1'b0;
      tap_k_d1                <= '0;
      tap_k_d2                <= '0;
      bus.ext_read_addr       <= '0;
      bus.ext_read_addr_valid <= 1'b0;
      bus.ext_write_addr      <= '0;
      bus.ext_write_valid     <= 1'b0;
      bus.ext_pixel_out       <= '0;
      bus.blur_done           <= 1'b0;
      bus.blur_data_valid_out <= 1'b0;
      bus.kernel_ind          <= '0;
    end else begin
      tap_v_d1 <= bus.ext_read_addr_valid;
      tap_k_d1 <= bus.kernel_ind;
      tap_v_d2 <= tap_v_d1;
      tap_k_d2 <= tap_k_d1;
      acc      <= acc_next;
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            x                       <= '0;
            y                       <= '0;
            pix_idx                 <= '0;
            acc                     <= '0;
            bus.kernel_ind          <= '0;
            bus.ext_read_addr       <= tap_addr(4'd0, XW'(0), YW'(0));
            bus.ext_read_addr_valid <= 1'b1;
            state                   <= READ;
          end
        end
        READ: begin
          if (bus.kernel_ind == 4'd8) begin
            bus.ext_read_addr_valid <= 1'b0;
            bus.kernel_ind          <= '0;
            drain_cnt               <= 1'b0;
            state                   <= DRAIN;
          end else begin
            bus.kernel_ind    <= bus.kernel_ind + 4'd1;
            bus.ext_read_addr <= tap_addr(bus.kernel_ind + 4'd1, x, y);
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            bus.ext_write_valid     <= 1'b1;
            bus.blur_data_valid_out <= 1'b1;
            bus.ext_write_addr      <= pix_idx;
            bus.ext_pixel_out       <= acc_next[ACC_W-1:4];
            state                   <= WRITE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        WRITE: begin
          bus.ext_write_valid     <= 1'b0;
          bus.blur_data_valid_out <= 1'b0;
          if (pix_idx == LAST_IDX) begin
            bus.blur_done <= 1'b1;
            state         <= DONE;
          end else begin
            x                       <= x_next;
            y                       <= y_next;
            pix_idx                 <= pix_idx + AW'(1);
            acc                     <= '0;
            bus.kernel_ind          <= '0;
            bus.ext_read_addr       <= tap_addr(4'd0, x_next, y_next);
            bus.ext_read_addr_valid <= 1'b1;
            state                   <= READ;
          end
        end
        DONE: begin
          bus.blur_done <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blur_img_core.sv
// Randomised and directed frames on a small image, checked against a direct 3x3 clamped convolution.
module tb_blur_img_core;
  localparam int BIT_DEPTH = 8;
  localparam int WIDTH     = 8;
  localparam int HEIGHT    = 6;
  localparam int NPIX      = WIDTH * HEIGHT;
  localparam int FRAME_CYC = 12 * NPIX;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  blur_img_core_if #(.BIT_DEPTH(BIT_DEPTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

  blur_img_core #(.BIT_DEPTH(BIT_DEPTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  int img [NPIX];
  int got [NPIX];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int dv_mismatch = 0;
  int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$], done_cyc_q[$];
  int first_wr_c, second_wr_c, done_c;
  logic [BIT_DEPTH-1:0] bram_r1;

  // Source BRAM: address register + output register = 2-cycle latency.
  always @(posedge clk_in) begin
    if (bus.ext_read_addr_valid) bram_r1 <= BIT_DEPTH'(img[bus.ext_read_addr]);
    bus.ext_pixel_in <= bram_r1;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  // Labels the cycle following edge cyc as cyc+1, so a start sampled at edge t shows tap 0 at t+1.
  always @(negedge clk_in) begin
    if (bus.ext_write_valid) begin
      wr_addr_q.push_back(int'(bus.ext_write_addr));
      wr_data_q.push_back(int'(bus.ext_pixel_out));
      wr_cyc_q.push_back(cyc + 1);
    end
    if (bus.blur_done) done_cyc_q.push_back(cyc + 1);
    if (bus.blur_data_valid_out !== bus.ext_write_valid) dv_mismatch++;
  end

  task automatic chk_val(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int blur_ref(input int px, input int py);
    int sum = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        sum += (2 - (dx < 0 ? -dx : dx)) * (2 - (dy < 0 ? -dy : dy)) *
               img[clampi(py + dy, HEIGHT - 1) * WIDTH + clampi(px + dx, WIDTH - 1)];
    return sum / 16;
  endfunction

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic pulse_start(output int t);
    @(posedge clk_in);
    #1 bus.start_in = 1'b1;
    t = cyc + 1;
    @(posedge clk_in);
    #1 bus.start_in = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk_val({tag, "_raddr"}, bus.ext_read_addr, 0);
    chk_val({tag, "_rvalid"}, bus.ext_read_addr_valid, 0);
    chk_val({tag, "_waddr"}, bus.ext_write_addr, 0);
    chk_val({tag, "_wvalid"}, bus.ext_write_valid, 0);
    chk_val({tag, "_pixout"}, bus.ext_pixel_out, 0);
    chk_val({tag, "_done"}, bus.blur_done, 0);
    chk_val({tag, "_dvalid"}, bus.blur_data_valid_out, 0);
    chk_val({tag, "_kind"}, bus.kernel_ind, 0);
  endtask

  task automatic run_and_check(input string tag);
    int n;
    for (int i = 0; i < FRAME_CYC + 50 && done_cyc_q.size() == 0; i++) @(negedge clk_in);
    repeat (3) @(negedge clk_in);
    chk_val({tag, "_done_pulses"}, done_cyc_q.size(), 1);
    chk_val({tag, "_nwrites"}, wr_addr_q.size(), NPIX);
    n = (wr_addr_q.size() < NPIX) ? wr_addr_q.size() : NPIX;
    for (int i = 0; i < n; i++) begin
      chk_val({tag, "_addr"}, wr_addr_q[i], i);
      chk_val({tag, "_pix"}, wr_data_q[i], blur_ref(i % WIDTH, i / WIDTH));
      got[i] = wr_data_q[i];
    end
    first_wr_c  = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1;
    second_wr_c = (wr_cyc_q.size() > 1) ? wr_cyc_q[1] : -1;
    done_c      = (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1;
    if (wr_cyc_q.size() > 0)
      chk_val({tag, "_done_after_last"}, done_c, wr_cyc_q[wr_cyc_q.size()-1] + 1);
    clear_logs();
  endtask

  initial begin
    int t0;
    bus.start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    check_zero_outputs("reset");

    // Uniform frame with cycle-exact timing of the first pixel.
    foreach (img[i]) img[i] = 100;
    pulse_start(t0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_in);
      chk_val("tap_kind", bus.kernel_ind, k);
      chk_val("tap_rvalid", bus.ext_read_addr_valid, 1);
      chk_val("tap_raddr", bus.ext_read_addr,
              clampi(k / 3 - 1, HEIGHT - 1) * WIDTH + clampi(k % 3 - 1, WIDTH - 1));
    end
    repeat (2) begin
      @(negedge clk_in);
      chk_val("drain_rvalid", bus.ext_read_addr_valid, 0);
      chk_val("drain_kind", bus.kernel_ind, 0);
    end
    run_and_check("uniform");
    chk_val("uniform_px0", got[0], 100);
    chk_val("first_write_cyc", first_wr_c, t0 + 12);
    chk_val("second_write_cyc", second_wr_c, t0 + 24);
    chk_val("done_cyc", done_c, t0 + FRAME_CYC + 1);

    // Interior impulse.
    foreach (img[i]) img[i] = 0;
    img[3 * WIDTH + 4] = 255;
    pulse_start(t0);
    run_and_check("impulse");
    chk_val("imp_center", got[3 * WIDTH + 4], 63);
    chk_val("imp_left", got[3 * WIDTH + 3], 31);
    chk_val("imp_up", got[2 * WIDTH + 4], 31);
    chk_val("imp_diag", got[2 * WIDTH + 3], 15);
    chk_val("imp_far", got[0], 0);

    // Corner impulse exercises clamping on two edges.
    foreach (img[i]) img[i] = 0;
    img[0] = 255;
    pulse_start(t0);
    run_and_check("corner");
    chk_val("corner_00", got[0], 143);
    chk_val("corner_10", got[1], 47);
    chk_val("corner_01", got[WIDTH], 47);
    chk_val("corner_11", got[WIDTH + 1], 15);

    // Horizontal ramp: linear interior, clamped ends.
    foreach (img[i]) img[i] = (i % WIDTH) * 4;
    pulse_start(t0);
    run_and_check("ramp");
    chk_val("ramp_x0", got[0], 1);
    chk_val("ramp_mid", got[2 * WIDTH + 3], 12);
    chk_val("ramp_xmax", got[WIDTH - 1], 4 * WIDTH - 5);

    // Random frame with a stray start pulse mid-frame.
    foreach (img[i]) img[i] = int'($urandom_range(0, 255));
    pulse_start(t0);
    repeat (100) @(negedge clk_in);
    pulse_start(t0);
    run_and_check("rand_restart_ignored");

    // Reset mid-frame aborts, then a fresh start reprocesses from pixel 0.
    foreach (img[i]) img[i] = int'($urandom_range(0, 255));
    pulse_start(t0);
    repeat (150) @(negedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    check_zero_outputs("midreset");
    clear_logs();
    repeat (60) @(negedge clk_in);
    chk_val("midreset_writes", wr_addr_q.size(), 0);
    chk_val("midreset_done", done_cyc_q.size(), 0);
    pulse_start(t0);
    run_and_check("after_reset");

    foreach (img[i]) img[i] = int'($urandom_range(0, 255));
    pulse_start(t0);
    run_and_check("rand2");

    chk_val("dvalid_eq_wvalid", dv_mismatch, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/blur_img_core.md
Name: blur_img_core

Overview:
- Sequential 3x3 Gaussian blur engine for one greyscale frame stored in an external single-port BRAM.
- On a start pulse it walks every pixel in raster order and reads the 9 neighbourhood taps through an external read port with 2-cycle latency.
- It accumulates the weighted sum (kernel 1 2 1 / 2 4 2 / 1 2 1, divided by 16) and emits one write per pixel to an external output memory.
- It is the first stage of the scale-space / DoG pipeline.

Parameters:
BIT_DEPTH, 8, pixel width in bits
WIDTH, 64, image width in pixels
HEIGHT, 64, image height in pixels

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_in  input  1  synchronous, active-high reset
ext_read_addr  output  $clog2(WIDTH*HEIGHT)  source BRAM address, y*WIDTH+x
ext_read_addr_valid  output  1  source BRAM enable; high while an address is issued
ext_pixel_in  input  BIT_DEPTH  source BRAM data, valid 2 cycles after the address is issued
ext_write_addr  output  $clog2(WIDTH*HEIGHT)  destination address, equal to the current pixel index
ext_write_valid  output  1  one-cycle write strobe
ext_pixel_out  output  BIT_DEPTH  blurred pixel value
start_in  input  1  one-cycle start pulse
blur_done  output  1  one-cycle pulse after the last pixel is written
blur_data_valid_out  output  1  identical to ext_write_valid
kernel_ind  output  4  index (0..8) of the tap whose address is being issued; 0 otherwise

Behaviour:
- Single clock domain.
- Reset:
  - synchronous, active-high on rst_in;
  - goes to IDLE; every output is 0; accumulator, pixel counter and tap counter are cleared.
  - Reset mid-frame aborts with no further writes and no blur_done.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - start_in high at a rising edge moves to READ on the next cycle, with pixel index 0 (x=0, y=0).
  - start_in is ignored in every other state.
- READ (9 cycles, k=0..8):
  - kernel_ind=k; ext_read_addr_valid=1.
  - Tap offset: dy=k/3-1, dx=k%3-1.
  - Coordinates are clamped to [0,WIDTH-1] and [0,HEIGHT-1] (edge replication); address = cy*WIDTH+cx.
- Data alignment:
  - ext_pixel_in for tap k is accumulated on cycle k+2 relative to the first READ cycle.
  - The accumulator is cleared on entry to READ.
  - Weight w(k) is 1,2,1,2,4,2,1,2,1 (shifts only, no multipliers).
  - Accumulator width is BIT_DEPTH+4 bits; it cannot overflow.
- DRAIN (2 cycles): ext_read_addr_valid=0, kernel_ind=0; the last two taps are accumulated.
- WRITE (1 cycle):
  - ext_write_valid=1 and blur_data_valid_out=1.
  - ext_write_addr = pixel index; ext_pixel_out = accumulator >> 4 (truncation, no rounding).
  - Then increment the pixel index (x first, wrapping to 0 and incrementing y). Next state is READ, or DONE after index WIDTH*HEIGHT-1.
- Per-pixel timing: 12 cycles exactly (9 READ + 2 DRAIN + 1 WRITE).
- Frame timing:
  - The first write occurs 12 cycles after the first READ cycle.
  - A frame takes WIDTH*HEIGHT*12 cycles (49152 at defaults) from the first READ cycle to the last write.
- DONE: blur_done=1 for exactly one cycle, then IDLE. A new start_in is accepted from IDLE; the frame is fully reprocessed.
- ext_write_addr and ext_pixel_out hold their last values between strobes. ext_read_addr holds its last value when valid=0.
- Source BRAM (xilinx_single_port_ram_read_first, HIGH_PERFORMANCE, regcea=1) supplies the 2-cycle latency. The block must not depend on the read data while valid=0.

Test Plan:
- Uniform image, all 100; pulse start -> 4096 writes, each ext_pixel_out=100; addresses 0..4095 in order, each exactly once; one blur_done pulse 1 cycle after the last write.
- Impulse 255 at (32,32), else 0 -> out(32,32)=63; (31,32),(33,32),(32,31),(32,33)=31; four diagonals=15; all others 0.
- Impulse 255 at corner (0,0) -> out(0,0)=143 (clamped weight 9); out(1,0)=out(0,1)=47; out(1,1)=15.
- Timing: start_in at edge t -> kernel_ind steps 0..8 on cycles t+1..t+9; first ext_write_valid at t+12; next at t+24; blur_done at t+49153.
- start_in re-pulsed mid-frame -> ignored, write sequence unchanged; assert rst_in for 1 cycle mid-frame -> all outputs 0, no blur_done, IDLE; a subsequent start reprocesses from pixel 0.
- Horizontal ramp, pixel = x*4 -> interior out = x*4 (linear preserved); out at x=0 is 1; out at x=63 is 251.
